// File: rtl/pp_width_fifo.sv
// Show-ahead valid/ready FIFO with wrap-bit pointers; width defaults to `WIDTH (8).
// Define PP_FIFO_LEVEL_EN to add the `level` occupancy output.
`ifndef WIDTH
`define WIDTH 8
`endif

module pp_width_fifo #(
    parameter int DATA_W = `WIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
`ifdef PP_FIFO_LEVEL_EN
   ,output logic [$clog2(DEPTH+1)-1:0] level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("pp_width_fifo: DEPTH must be a power of two >= 2");
    end

    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                       full, empty, push, pop;

    // Same index with opposite wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is deliberately left out of reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr[AW-1:0]] <= in_data;
    end

    assign out_data = out_valid ? mem[rd_ptr[AW-1:0]] : '0;

`ifdef PP_FIFO_LEVEL_EN
    assign level = $bits(level)'(wr_ptr - rd_ptr);
`endif

endmodule
